// File: rtl/button_sequencer.sv
// ============================================================================
// Module   : button_sequencer
// Brief    : Synchronises, debounces and arbitrates the clock-setting buttons
//            into one-cycle command strobes, with long-press auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_sequencer #(
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] msr,
  output logic [1:0] op,
  output logic       op_valid,
  output logic       pause
);

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  localparam logic [1:0] c_OP_NONE = 2'b00;
  localparam logic [1:0] c_OP_MIN  = 2'b01;
  localparam logic [1:0] c_OP_SEC  = 2'b10;
  localparam logic [1:0] c_OP_CLR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_FIRE     = 3'd2,
    S_HOLD     = 3'd3,
    S_REPEAT   = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  logic [2:0]       r_sync1;
  logic [2:0]       r_ms;
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_rep;
  logic             w_rep_nx;
  logic [1:0]       r_key;
  logic [1:0]       w_key_nx;
  logic             w_key_held;
  logic [1:0]       r_op;
  logic             r_op_valid;
  logic             r_pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_ms    <= 3'b000;
    end else begin
      r_sync1 <= msr;
      r_ms    <= r_sync1;
    end
  end

  // Only the button that won arbitration keeps the sequence alive.
  always_comb begin
    w_key_held = 1'b0;
    case (r_key)
      c_OP_CLR: w_key_held = r_ms[0];
      c_OP_MIN: w_key_held = r_ms[2];
      c_OP_SEC: w_key_held = r_ms[1];
      default:  w_key_held = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rep_nx   = r_rep;
    w_key_nx   = r_key;
    case (r_state)
      S_IDLE: begin
        if (r_ms != 3'b000) begin
          w_key_nx   = r_ms[0] ? c_OP_CLR : (r_ms[2] ? c_OP_MIN : c_OP_SEC);
          w_cnt_nx   = '0;
          w_rep_nx   = 1'b0;
          w_state_nx = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!w_key_held) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else if (r_cnt == c_DEB_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_FIRE;
        end else begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
        end
      end
      S_FIRE: begin
        w_cnt_nx = '0;
        if (!w_key_held || (r_key == c_OP_CLR)) begin
          w_state_nx = S_RELEASE;
        end else if (!r_rep) begin
          w_state_nx = S_HOLD;
        end else begin
          w_state_nx = S_REPEAT;
        end
      end
      S_HOLD: begin
        if (!w_key_held) begin
          w_cnt_nx   = '0;
          w_state_nx = S_RELEASE;
        end else if (r_cnt == c_HOLD_LAST) begin
          w_cnt_nx   = '0;
          w_rep_nx   = 1'b1;
          w_state_nx = S_FIRE;
        end else begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
        end
      end
      S_REPEAT: begin
        if (!w_key_held) begin
          w_cnt_nx   = '0;
          w_state_nx = S_RELEASE;
        end else if (r_cnt == c_REP_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_FIRE;
        end else begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
        end
      end
      S_RELEASE: begin
        // Any button, not just the latched one, restarts the quiet period.
        if (r_ms != 3'b000) begin
          w_cnt_nx = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rep      <= 1'b0;
      r_key      <= c_OP_NONE;
      r_op       <= c_OP_NONE;
      r_op_valid <= 1'b0;
      r_pause    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_rep      <= w_rep_nx;
      r_key      <= w_key_nx;
      // Outputs track the state being entered so they align with it.
      r_op_valid <= (w_state_nx == S_FIRE);
      r_op       <= (w_state_nx == S_FIRE) ? w_key_nx : c_OP_NONE;
      r_pause    <= (w_state_nx != S_IDLE);
    end
  end

  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign pause    = r_pause;

endmodule

`default_nettype wire

// File: tb/tb_button_sequencer.sv
// ============================================================================
// Module   : tb_button_sequencer
// Brief    : Directed self-checking bench for button_sequencer (4/10/3 timing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] msr;
  logic [1:0] op;
  logic       op_valid;
  logic       pause;

  int n_checks;
  int n_fail;

  button_sequencer #(
    .CNT_W          (8),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .msr     (msr),
    .op      (op),
    .op_valid(op_valid),
    .pause   (pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Observed/expected are {pause, op_valid, op}.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got pause/valid/op=%b, expected %b", tag, obs, exp);
    end
  endtask

  // Edge e samples msr; outputs checked 1ns after edge e.
  // msr = p0 for e<l0, p1 for e<l1, p2 for e<l2, else 0.
  // Strobes expected at edge 6 (if first) and at 17+4k up to last_rep.
  task automatic run_seq(input string name,
                         input logic [2:0] p0, input int l0,
                         input logic [2:0] p1, input int l1,
                         input logic [2:0] p2, input int l2,
                         input logic [1:0] code, input bit first,
                         input int last_rep, input int pause_end, input int n);
    logic exp_v;
    logic exp_p;
    for (int e = 0; e < n; e++) begin
      msr = (e < l0) ? p0 : (e < l1) ? p1 : (e < l2) ? p2 : 3'b000;
      @(posedge clk);
      #1;
      exp_v = (first && e == 6) ||
              (e >= 17 && e <= last_rep && ((e - 17) % 4) == 0);
      exp_p = (e >= 2) && (e <= pause_end);
      check($sformatf("%s@%0d", name, e), {pause, op_valid, op},
            {exp_p, exp_v, (exp_v ? code : 2'b00)});
    end
    msr = 3'b000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    msr = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {pause, op_valid, op}, 4'b0000);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {pause, op_valid, op}, 4'b0000);

    run_seq("min_single",   3'b100, 8,  3'b100, 8,  3'b100, 8,  2'b01, 1, 0,  13, 18);
    run_seq("sec_bounce",   3'b010, 3,  3'b010, 3,  3'b010, 3,  2'b10, 0, 0,  4,  10);
    run_seq("deb_drop_exp", 3'b010, 4,  3'b010, 4,  3'b010, 4,  2'b10, 0, 0,  5,  10);
    run_seq("hold_drop_exp",3'b100, 15, 3'b100, 15, 3'b100, 15, 2'b01, 1, 0,  20, 25);
    run_seq("sec_repeat",   3'b010, 60, 3'b010, 60, 3'b010, 60, 2'b10, 1, 61, 65, 72);
    run_seq("clr_priority", 3'b101, 40, 3'b101, 40, 3'b101, 40, 2'b11, 1, 0,  44, 50);
    run_seq("min_over_sec", 3'b110, 8,  3'b110, 8,  3'b110, 8,  2'b01, 1, 0,  13, 18);
    run_seq("overlap",      3'b100, 3,  3'b110, 14, 3'b010, 25, 2'b01, 1, 0,  29, 35);

    // Mid-repeat reset: FSM is in REPEAT after edge 19.
    run_seq("pre_rst",      3'b100, 30, 3'b100, 30, 3'b100, 30, 2'b01, 1, 17, 999, 20);
    msr = 3'b100;
    rst = 1'b1;
    #1;
    check("rst_async_drop", {pause, op_valid, op}, 4'b0000);
    msr = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold@%0d", i), {pause, op_valid, op}, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst@%0d", i), {pause, op_valid, op}, 4'b0000);
    end
    run_seq("fresh_press",  3'b100, 8,  3'b100, 8,  3'b100, 8,  2'b01, 1, 0,  13, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
